// File: rtl/cr_xp10_comp_ftr_patch.sv
// XP10 compressor egress TLV footer patcher: counts DATA payload bytes and writes the count into FTR bytes_out.
// Optional build macro CR_XP10_FTR_PATCH_CHECK_EN adds the ftr_mismatch pulse output.
module cr_xp10_comp_ftr_patch #(
  parameter logic [7:0] DATA_TYPE      = 8'h02,
  parameter logic [7:0] FTR_TYPE       = 8'h0A,
  parameter int         FTR_PATCH_WORD = 12,
  parameter int         CNT_W          = 32
) (
  input  logic        clk,
  input  logic        rst_sync_n,
  input  logic        ib_tvalid,
  output logic        ib_tready,
  input  logic [63:0] ib_tdata,
  input  logic [7:0]  ib_tstrb,
  input  logic [7:0]  ib_tuser,
  input  logic        ib_tid,
  input  logic        ib_tlast,
  output logic        ob_tvalid,
  input  logic        ob_tready,
  output logic [63:0] ob_tdata,
  output logic [7:0]  ob_tstrb,
  output logic [7:0]  ob_tuser,
  output logic        ob_tid,
  output logic        ob_tlast,
  output logic        frame_done,
  output logic        cnt_sat
`ifdef CR_XP10_FTR_PATCH_CHECK_EN
  ,
  output logic        ftr_mismatch
`endif
);

  // state    | meaning
  // ST_IDLE  | between TLVs
  // ST_OTHER | inside a TLV of an unhandled type
  // ST_DATA  | inside a DATA TLV, payload words are counted
  // ST_FTR   | inside the FTR TLV, word_idx tracks the word position
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_OTHER = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_FTR   = 2'd3;
  localparam logic [7:0] PATCH_IDX = 8'(FTR_PATCH_WORD);
  localparam int         WORD_W = 82;

  logic [1:0]       state, state_nxt;
  logic [7:0]       word_idx, word_idx_nxt;
  logic [CNT_W-1:0] byte_cnt, cnt_new, cnt_nxt;
  logic [CNT_W:0]   cnt_sum;
  logic [3:0]       strb_cnt;
  logic             in_xfer, sot, eot, cnt_add, cnt_ovf, patch_hit, ftr_eot;
  logic             ob_free, skid_vld, skid_nxt;
  logic [63:0]      data_mod;
  logic [WORD_W-1:0] in_word, ob_word, skid_word;

  always_comb begin
    in_xfer  = ib_tvalid & ib_tready;
    sot      = ib_tuser[0];
    eot      = ib_tuser[1];
    strb_cnt = 4'($countones(ib_tstrb));
    cnt_add  = !sot && (state == ST_DATA);
    cnt_sum  = {1'b0, byte_cnt} + {{(CNT_W-3){1'b0}}, strb_cnt};
    cnt_ovf  = cnt_add & cnt_sum[CNT_W];
    cnt_new  = byte_cnt;
    if (cnt_add) cnt_new = cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
    patch_hit = !sot && (state == ST_FTR) && (word_idx == PATCH_IDX);
    ftr_eot   = eot && (sot ? (ib_tdata[7:0] == FTR_TYPE) : (state == ST_FTR));
    data_mod  = ib_tdata;
    if (patch_hit) data_mod[CNT_W+31:32] = cnt_new;
    in_word = {data_mod, ib_tstrb, ib_tuser, ib_tid, ib_tlast};

    state_nxt    = state;
    word_idx_nxt = word_idx;
    if (sot) begin
      if (ib_tdata[7:0] == DATA_TYPE)     state_nxt = ST_DATA;
      else if (ib_tdata[7:0] == FTR_TYPE) state_nxt = ST_FTR;
      else                                state_nxt = ST_OTHER;
      word_idx_nxt = (ib_tdata[7:0] == FTR_TYPE) ? 8'd1 : 8'd0;
    end else if (state == ST_FTR && word_idx != 8'hFF) begin
      word_idx_nxt = word_idx + 8'd1;
    end
    if (eot) state_nxt = ST_IDLE;
    if (ftr_eot) word_idx_nxt = 8'd0;
    cnt_nxt = ftr_eot ? '0 : cnt_new;

    // Output register is free when empty or draining this cycle; the skid slot only fills while it is stuck.
    ob_free  = !ob_tvalid || ob_tready;
    skid_nxt = ob_free ? 1'b0 : (skid_vld | in_xfer);
  end

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state      <= ST_IDLE;
      word_idx   <= 8'd0;
      byte_cnt   <= '0;
      cnt_sat    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= in_xfer & ftr_eot;
      if (in_xfer) begin
        state    <= state_nxt;
        word_idx <= word_idx_nxt;
        byte_cnt <= cnt_nxt;
        cnt_sat  <= ftr_eot ? 1'b0 : (cnt_sat | cnt_ovf);
      end
    end
  end

`ifdef CR_XP10_FTR_PATCH_CHECK_EN
  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) ftr_mismatch <= 1'b0;
    else ftr_mismatch <= in_xfer && patch_hit && (ib_tdata[CNT_W+31:32] != '0) &&
                         (ib_tdata[CNT_W+31:32] != cnt_new);
  end
`endif

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      ob_tvalid <= 1'b0;
      skid_vld  <= 1'b0;
      ib_tready <= 1'b0;
    end else begin
      skid_vld  <= skid_nxt;
      ib_tready <= !skid_nxt;
      if (ob_free) ob_tvalid <= skid_vld | in_xfer;
    end
  end

  always_ff @(posedge clk) begin
    if (ob_free) begin
      if (skid_vld)     ob_word <= skid_word;
      else if (in_xfer) ob_word <= in_word;
    end else if (in_xfer) begin
      skid_word <= in_word;
    end
  end

  assign {ob_tdata, ob_tstrb, ob_tuser, ob_tid, ob_tlast} = ob_word;

endmodule

// File: tb/tb_cr_xp10_comp_ftr_patch.sv
// Randomised bench for the FTR patcher: a TLV-level reference model predicts the output word stream and pulses.
module tb_cr_xp10_comp_ftr_patch;
  localparam logic [7:0] DT = 8'h02;
  localparam logic [7:0] FT = 8'h0A;
  localparam int PW = 12;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  s;
    logic [7:0]  u;
    logic        id;
    logic        last;
  } word_t;

  logic clk = 1'b0, rst_sync_n = 1'b0;
  logic ib_tvalid = 1'b0, ib_tready, ib_tid = 1'b0, ib_tlast = 1'b0;
  logic [63:0] ib_tdata = '0;
  logic [7:0]  ib_tstrb = '0, ib_tuser = '0;
  logic ob_tvalid, ob_tready = 1'b1, ob_tid, ob_tlast, frame_done, cnt_sat;
  logic [63:0] ob_tdata;
  logic [7:0]  ob_tstrb, ob_tuser;
`ifdef CR_XP10_FTR_PATCH_CHECK_EN
  logic ftr_mismatch;
`endif

  cr_xp10_comp_ftr_patch dut (
    .clk(clk), .rst_sync_n(rst_sync_n),
    .ib_tvalid(ib_tvalid), .ib_tready(ib_tready), .ib_tdata(ib_tdata), .ib_tstrb(ib_tstrb),
    .ib_tuser(ib_tuser), .ib_tid(ib_tid), .ib_tlast(ib_tlast),
    .ob_tvalid(ob_tvalid), .ob_tready(ob_tready), .ob_tdata(ob_tdata), .ob_tstrb(ob_tstrb),
    .ob_tuser(ob_tuser), .ob_tid(ob_tid), .ob_tlast(ob_tlast),
    .frame_done(frame_done), .cnt_sat(cnt_sat)
`ifdef CR_XP10_FTR_PATCH_CHECK_EN
    , .ftr_mismatch(ftr_mismatch)
`endif
  );

  always #5 clk = ~clk;

  word_t in_q[$];
  word_t exp_q[$];
  bit    exp_patch_q[$];
  logic [7:0] sq[$];
  int n_cmp = 0, n_err = 0;
  longint unsigned m_cnt = 0;
  bit m_sat = 0;
  int exp_done = 0, got_done = 0, exp_mm = 0, got_mm = 0;
  logic [31:0] last_patch = '0;
  int ready_mode = 0, cyc = 0, low_run = 0;
  bit stall_pending = 0;
  logic [82:0] held;

  function automatic void chk(string nm, logic [95:0] act, logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // Model: one TLV at a time, expected words derived from the TLV rules.
  task automatic send_tlv(input logic [7:0] typ, input int nw, input int emit, input logic [31:0] field);
    word_t w, e;
    logic [7:0] st;
    bit patch;
    for (int i = 0; i < emit; i++) begin
      if (i == 0 || sq.size() == 0) st = 8'hFF;
      else st = sq.pop_front();
      w.d = {$urandom, $urandom};
      if (i == 0) w.d[7:0] = typ;
      if (typ == FT && i == PW) w.d[63:32] = field;
      w.s = st;
      w.u = {6'($urandom), (i == nw - 1), (i == 0)};
      w.id = 1'($urandom);
      w.last = (typ == FT) && (i == nw - 1);
      e = w;
      if (typ == DT && i > 0) begin
        m_cnt += $countones(st);
        if (m_cnt > 64'hFFFF_FFFF) begin m_cnt = 64'hFFFF_FFFF; m_sat = 1; end
      end
      patch = (typ == FT) && (i == PW);
      if (patch) begin
        e.d[63:32] = m_cnt[31:0];
        if (field != 0 && field != m_cnt[31:0]) exp_mm++;
      end
      if (typ == FT && i == nw - 1) begin exp_done++; m_cnt = 0; m_sat = 0; end
      in_q.push_back(w);
      exp_q.push_back(e);
      exp_patch_q.push_back(patch);
    end
  endtask

  task automatic run();
    int guard = 0;
    bit hold = 0, acc;
    while (in_q.size() > 0 && guard < 20000) begin
      ib_tvalid = hold || ($urandom_range(0, 3) != 0);
      {ib_tdata, ib_tstrb, ib_tuser, ib_tid, ib_tlast} = in_q[0];
      @(negedge clk);
      acc = ib_tvalid && ib_tready;
      @(posedge clk); #1;
      if (acc) begin void'(in_q.pop_front()); hold = 0; end
      else hold = ib_tvalid;
      guard++;
    end
    ib_tvalid = 1'b0;
    while (exp_q.size() > 0 && guard < 20000) begin @(posedge clk); guard++; end
    repeat (3) @(posedge clk);
    #1;
    if (guard >= 20000) begin
      n_cmp++; n_err++;
      $display("FAIL timeout: in_q %0d exp_q %0d words left", in_q.size(), exp_q.size());
      in_q.delete(); exp_q.delete(); exp_patch_q.delete();
    end
    chk("frame_done_count", got_done, exp_done);
    chk("cnt_sat", cnt_sat, m_sat);
`ifdef CR_XP10_FTR_PATCH_CHECK_EN
    chk("ftr_mismatch_count", got_mm, exp_mm);
`endif
  endtask

  task automatic do_reset();
    ib_tvalid = 1'b0;
    @(negedge clk); #2 rst_sync_n = 1'b0;
    #1;
    chk("rst_ob_tvalid", ob_tvalid, 0);
    chk("rst_ib_tready", ib_tready, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_cnt_sat", cnt_sat, 0);
    m_cnt = 0; m_sat = 0;
    in_q.delete(); exp_q.delete(); exp_patch_q.delete();
    repeat (3) @(posedge clk);
    #3 rst_sync_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ib_tready", ib_tready, 1);
  endtask

  always @(posedge clk) begin
    #1;
    cyc++;
    case (ready_mode)
      0: ob_tready = 1'b1;
      1: ob_tready = ($urandom_range(0, 2) != 0);
      default: ob_tready = (cyc % 4 == 0) || (cyc % 4 == 3);
    endcase
  end

  always @(negedge clk) begin
    word_t e;
    bit p;
    if (!rst_sync_n) begin
      stall_pending = 0;
      low_run = 0;
    end else begin
      if (frame_done) got_done++;
`ifdef CR_XP10_FTR_PATCH_CHECK_EN
      if (ftr_mismatch) got_mm++;
`endif
      if (stall_pending)
        chk("ob_hold", {ob_tvalid, ob_tdata, ob_tstrb, ob_tuser, ob_tid, ob_tlast}, held);
      stall_pending = ob_tvalid && !ob_tready;
      held = {1'b1, ob_tdata, ob_tstrb, ob_tuser, ob_tid, ob_tlast};
      if (ob_tvalid && ob_tready) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL extra_word: got %0h expected none", ob_tdata);
        end else begin
          e = exp_q.pop_front();
          p = exp_patch_q.pop_front();
          chk("ob_word", {ob_tdata, ob_tstrb, ob_tuser, ob_tid, ob_tlast}, e);
          if (p) last_patch = ob_tdata[63:32];
        end
      end
      if (!ib_tready) low_run++;
      else begin
        if (low_run > 0 && ready_mode == 2) chk("ib_tready_low_run_gt2", (low_run > 2), 0);
        low_run = 0;
      end
    end
  end

  task automatic basic_frame();
    sq = '{8'hFF, 8'hFF, 8'hFF, 8'h0F};
    send_tlv(DT, 5, 5, 0);
    send_tlv(FT, 13, 13, 0);
    run();
    chk("bytes_out_28", last_patch, 32'd28);
  endtask

  initial begin
    int nt, nw, emit;
    logic [31:0] fld;
    #1;
    chk("init_ob_tvalid", ob_tvalid, 0);
    chk("init_ib_tready", ib_tready, 0);
    do_reset();

    ready_mode = 0;
    basic_frame();
    chk("frame_done_one", got_done, 1);
    ready_mode = 2;
    basic_frame();
    ready_mode = 0;

    sq = '{8'hFF, 8'h03};
    send_tlv(DT, 3, 3, 0);
    send_tlv(FT, 13, 13, 0);
    run();
    chk("bytes_out_10", last_patch, 32'd10);
    sq = '{8'h7F};
    send_tlv(DT, 2, 2, 0);
    send_tlv(FT, 13, 13, 0);
    run();
    chk("bytes_out_7", last_patch, 32'd7);

    sq = '{8'hFF};
    send_tlv(DT, 2, 2, 0);
    send_tlv(8'h05, 3, 3, 0);
    sq = '{8'hFF};
    send_tlv(DT, 2, 2, 0);
    send_tlv(FT, 13, 13, 0);
    run();
    chk("bytes_out_16", last_patch, 32'd16);

    ready_mode = 1;
    for (int f = 0; f < 25; f++) begin
      nt = $urandom_range(0, 3);
      for (int t = 0; t < nt; t++) begin
        if ($urandom_range(0, 2) != 0) begin
          nw = $urandom_range(1, 6);
          for (int k = 1; k < nw; k++) sq.push_back(8'($urandom_range(1, 255)));
          emit = ($urandom_range(0, 5) == 0) ? $urandom_range(1, nw) : nw;
          send_tlv(DT, nw, emit, 0);
          sq.delete();
        end else begin
          send_tlv(8'h05, $urandom_range(1, 4), 0, 0);
          nw = $urandom_range(1, 4);
          send_tlv(8'h05, nw, nw, 0);
        end
      end
      nw = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 12) : $urandom_range(13, 16);
      fld = ($urandom_range(0, 1) == 0) ? 32'd0 : $urandom;
      send_tlv(FT, nw, nw, fld);
      run();
    end
    ready_mode = 0;

    force dut.byte_cnt = 32'hFFFF_FFFC;
    repeat (2) @(posedge clk);
    #1 release dut.byte_cnt;
    m_cnt = 64'hFFFF_FFFC;
    sq = '{8'hFF};
    send_tlv(DT, 2, 2, 0);
    run();
    chk("sat_set", cnt_sat, 1);
    send_tlv(FT, 13, 13, 0);
    run();
    chk("bytes_out_sat", last_patch, 32'hFFFF_FFFF);
    chk("sat_cleared", cnt_sat, 0);

    sq = '{8'hFF};
    send_tlv(DT, 5, 2, 0);
    run();
    do_reset();
    got_mm = 0; exp_mm = 0;
    sq = '{8'h1F};
    send_tlv(DT, 2, 2, 0);
    send_tlv(FT, 13, 13, 32'd6);
    run();
    chk("bytes_out_after_rst", last_patch, 32'd5);
`ifdef CR_XP10_FTR_PATCH_CHECK_EN
    chk("ftr_mismatch_once", got_mm, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
